fifo_share_ctrl: RTL
====================

// Module: fifo_share_ctrl
// PURPOSE
//  Controller that shares one register-based FIFO (WIDTH x DEPTH) between NREQ writers and one reader.
//  Round-robin arbitrates write requests onto the FIFO's wdata/shift_in.
//  Gates reader shift_out, tracks fill level, and sequences a flush (drain-to-empty) operation.
//  Sits between the requesting producers/consumer and the FIFO instance.
// PARAMETERS
//  NREQ   4  number of write requesters (>=2)
//  WIDTH  4  data word width, equal to FIFO WIDTH
//  DEPTH  5  FIFO depth, equal to FIFO N; sizes level counter
//  BURST  4  max consecutive grants to one requester (used only with FIFO_SHARE_BURST_EN)
// PORTS
//  clk            in   1           clock, rising edge
//  res            in   1           reset, synchronous, active-high
//  req            in   NREQ        write request per requester; held with data until granted
//  req_data       in   NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
//  gnt            out  NREQ        one-hot accept; word is written this cycle
//  rd_req         in   1           reader pop request
//  rd_ack         out  1           pop accepted this cycle; rdata valid this cycle
//  rdata          out  WIDTH       = fifo_rdata (pass-through)
//  flush          in   1           start drain; sampled in RUN only
//  flush_busy     out  1           high in FLUSH state
//  flush_done     out  1           1-cycle pulse on FLUSH->RUN
//  level          out  $clog2(DEPTH+1)  current word count
//  fifo_wdata     out  WIDTH       to FIFO wdata
//  fifo_shift_in  out  1           to FIFO shift_in
//  fifo_shift_out out  1           to FIFO shift_out
//  fifo_rdata     in   WIDTH       from FIFO rdata
//  fifo_full      in   1           from FIFO full
//  fifo_empty     in   1           from FIFO empty
// BEHAVIOUR
//  Reset (res=1 at edge): state=RUN, rr pointer=0, level=0, burst count=0, flush_done=0.
//   All combinational outputs are low while the FIFO is empty and req=0.
//  FSM RUN:
//   - winner = first i with req[i], searching from pointer upward, modulo NREQ.
//   - gnt[winner] = fifo_full==0; fifo_shift_in = |gnt; fifo_wdata = winner's data (0 if none).
//   - rd_ack = fifo_shift_out = rd_req & ~fifo_empty.
//   - Write and read in the same cycle are both allowed, even when the FIFO is full or empty.
//   - flush=1 -> FLUSH next cycle. A grant in the flush cycle still completes.
//  FSM FLUSH:
//   - gnt=0, rd_ack=0; fifo_shift_out = ~fifo_empty every cycle.
//   - When fifo_empty=1 -> RUN next cycle and flush_done=1 for that one cycle.
//   - flush is ignored while in FLUSH.
//  Latency: grant and pop are zero-cycle (combinational). Pointer, level and state update at the edge.
//  Pointer: after a grant to i, pointer = (i+1) mod NREQ. Unchanged when there is no grant.
//  level: +1 on shift_in only, -1 on shift_out only, unchanged on both or neither.
//   Never wraps; must stay equal to the FIFO occupancy.
//  Reset mid-operation (including mid-FLUSH) returns the block to the reset state.
//   The FIFO must be reset in the same cycle.
// CONFIGURATION
//  FIFO_SHARE_BURST_EN defined:
//   - The granted requester keeps priority (pointer is not advanced) while it keeps req=1.
//   - This holds until it has BURST consecutive grants; then pointer = i+1 and burst count clears.
//   - Burst count clears whenever another requester is granted.
//  FIFO_SHARE_BURST_EN undefined: strict round-robin, pointer advances after every grant.
//   No burst counter logic.
// STRUCTURE
//  Shared package fifo_share_pkg:
//   - state encodings ST_RUN=1'b0, ST_FLUSH=1'b1
//   - level-width helper function.
//  Sub-module rr_pick: combinational rotated priority encoder (req, pointer -> one-hot, index, valid).
// TESTING
//  1 Reset: res=1 for 2 cycles with req=4'b1111 -> gnt=0, level=0, flush_busy=0 after release.
//  2 RR fairness: req=4'b1011 held, FIFO never full, reader popping every cycle
//    -> gnt order 0,1,3,0,1,3 (burst off).
//  3 Full: 5 writes with no reads -> level=5, fifo_full=1, gnt=0.
//    One rd_req plus a write in the same cycle -> level stays 5.
//  4 Flush: level=3, pulse flush -> flush_busy for 3 drain cycles, gnt=0 despite req,
//    flush_done pulse, then level=0.
//  5 Burst (FIFO_SHARE_BURST_EN, BURST=4): req=4'b0011 held -> gnt 0,0,0,0,1,1,1,1,0.
//  6 Empty read: rd_req=1 with fifo_empty=1 -> rd_ack=0, fifo_shift_out=0, level stays 0.

Source files
------------

// File: rtl/fifo_share_pkg.sv
// fifo_share_pkg: shared state encodings and level-width helper for fifo_share_ctrl
package fifo_share_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_share_ctrl_rr_pick.sv
// rr_pick: rotated priority encoder, first request at or above ptr (modulo N) wins
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] j;
  // Descending scan so the smallest rotation offset is assigned last and wins
  always_comb begin
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx = j;
        valid = 1'b1;
      end
    end
    onehot = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: round-robin write sharing, read gating, level tracking and flush sequencing for one FIFO.
// Define FIFO_SHARE_BURST_EN to let a granted requester keep priority for up to BURST grants.
module fifo_share_ctrl import fifo_share_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
`ifdef FIFO_SHARE_BURST_EN
  , parameter int BURST = 4
`endif
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           gnt,
  input  logic                      rd_req,
  output logic                      rd_ack,
  output logic [WIDTH-1:0]          rdata,
  input  logic                      flush,
  output logic                      flush_busy,
  output logic                      flush_done,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [WIDTH-1:0]          fifo_wdata,
  output logic                      fifo_shift_in,
  output logic                      fifo_shift_out,
  input  logic [WIDTH-1:0]          fifo_rdata,
  input  logic                      fifo_full,
  input  logic                      fifo_empty
);
  localparam int PW = $clog2(NREQ);
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, widx, nxt;
  logic [NREQ-1:0] pick;
  logic [lvl_w(DEPTH)-1:0] level_n;
  logic valid, run, live;
`ifdef FIFO_SHARE_BURST_EN
  localparam int BW = $clog2(BURST + 1);
  logic [BW-1:0] bcnt, bcnt_n, bcnt_inc;
  logic bsat;
`endif
  rr_pick #(.N(NREQ)) u_pick (.req(req), .ptr(ptr), .onehot(pick), .idx(widx), .valid(valid));
  // Nothing is granted or popped while in reset: the FIFO is being cleared in the same cycle
  always_comb begin
    run = state == ST_RUN;
    live = ~res;
    rd_ack = live & run & rd_req & ~fifo_empty;
    gnt = (live & run & valid & (~fifo_full | rd_ack)) ? pick : '0;
    fifo_shift_in = |gnt;
    fifo_wdata = fifo_shift_in ? req_data[int'(widx)*WIDTH +: WIDTH] : '0;
    fifo_shift_out = run ? rd_ack : live & ~fifo_empty;
    flush_busy = state == ST_FLUSH;
    rdata = fifo_rdata;
    state_n = run ? (flush ? ST_FLUSH : ST_RUN) : (fifo_empty ? ST_RUN : ST_FLUSH);
    level_n = (fifo_shift_in & ~fifo_shift_out) ? level + 1'b1 :
              (~fifo_shift_in & fifo_shift_out) ? level - 1'b1 : level;
    nxt = (widx == PW'(NREQ - 1)) ? '0 : widx + 1'b1;
`ifdef FIFO_SHARE_BURST_EN
    bcnt_inc = (widx == ptr ? bcnt : '0) + 1'b1;
    bsat = bcnt_inc == BW'(BURST);
    ptr_n = !fifo_shift_in ? ptr : bsat ? nxt : widx;
    bcnt_n = !fifo_shift_in ? bcnt : bsat ? '0 : bcnt_inc;
`else
    ptr_n = fifo_shift_in ? nxt : ptr;
`endif
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state <= ST_RUN;
      ptr <= '0;
      level <= '0;
      flush_done <= 1'b0;
`ifdef FIFO_SHARE_BURST_EN
      bcnt <= '0;
`endif
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      level <= level_n;
      flush_done <= ~run & fifo_empty;
`ifdef FIFO_SHARE_BURST_EN
      bcnt <= bcnt_n;
`endif
    end
  end
endmodule
